slice_rate_buffer: RTL and testbench
====================================

# slice_rate_buffer

Per-slice decoder rate buffer, one instance per slice, downstream of the slice demultiplexer. It accepts the demux's valid-only stream of 256-bit compressed words for one slice and strips PPS words. It holds output until a programmed initial fill level is reached, then presents words to the slice's substream demux/decoder over a valid/ready handshake. It detects overflow, underflow and missing start-of-frame conditions with sticky flags.

## Interface
- DEPTH, 64: storage words, power of two, ≥4; ADDR_W = $clog2(DEPTH)
- DATA_W, 256: word width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of contents, state and flags
- start_level  in  ADDR_W+1  fill level (words) required before first output of a frame; quasi-static
- in_valid  in  1  input word valid (no backpressure)
- in_data  in  DATA_W  input word
- in_sof  in  1  word is first of a frame for this slice (sampled only with in_valid)
- in_is_pps  in  1  word belongs to PPS; never stored
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word
- out_data  out  DATA_W  output word
- out_sof  out  1  out_data is first word of a frame
- fill_level  out  ADDR_W+2  words in memory + output register
- overflow  out  1  sticky: a word was dropped because memory was full
- underflow  out  1  sticky: STREAM, out_ready=1, out_valid=0
- sync_err  out  1  sticky: non-PPS word received in IDLE without in_sof

## Operation
- Storage: DEPTH×(DATA_W+1) entries, bit DATA_W = sof tag. Write pointer and read pointer are ADDR_W bits and wrap modulo DEPTH. mem_count is ADDR_W+1 bits.
- Write qualifier: wr = in_valid & ~in_is_pps & ~flush & (state≠IDLE | in_sof).
- Full check uses the registered mem_count==DEPTH before the edge. A word arriving when full is dropped and sets overflow, even if a pop occurs in the same cycle.
- Output register: first-word-fall-through.
  - When it is empty or being consumed (out_valid & out_ready) and mem_count>0 and state==STREAM, it loads the head entry.
  - When it is empty, the entry is being written this cycle and mem_count==0 in STREAM, the load happens on the next edge; there is no bypass.
- States:
  - IDLE: reset/flush state, nothing stored. A wr with in_sof=1 → PRIME and stores the word. A non-PPS in_valid without in_sof is dropped and sets sync_err.
  - PRIME: words stored, out_valid=0. → STREAM when mem_count ≥ start_level (evaluated on registered count). start_level=0 is treated as 1.
  - STREAM: normal flow. Later sof-tagged words are stored and emitted with out_sof=1, with no state change. It leaves STREAM only via flush/reset.
- underflow is set at any edge in STREAM with out_ready=1 & out_valid=0.
- flush wins over every simultaneous event: pointers, mem_count, output register, flags → 0; state → IDLE.

## Timing
- Reset values: out_valid=0, out_data=0, out_sof=0, fill_level=0, overflow=0, underflow=0, sync_err=0, state IDLE.
- All outputs are registered.
- Latency in STREAM with empty buffer: word written at edge N, appears on out_valid/out_data after edge N+1.
- PRIME→STREAM transition at edge M: first out_valid after edge M+1.
- Throughput: one write and one read per cycle sustained.
- fill_level reflects the state after each edge: mem_count + out_valid.
- Handshake: once asserted, out_valid/out_data/out_sof hold until out_ready is sampled high.

## Structure
- Shared decoder package: DATA_W default, state enum (IDLE, PRIME, STREAM), sof tag bit index.
- One sub-module, rb_ram: simple dual-port synchronous RAM, DEPTH×(DATA_W+1), registered read. It has no reset, so it infers block RAM.
- Control (pointers, count, FSM, output register, flags) lives in the top.

## Test plan
- DEPTH=64, start_level=4. Four words 0xA0..0xA3 with sof on the first, out_ready=1. out_valid stays 0 until the 4th write; out_valid rises two edges after it, with 0xA0 and out_sof=1, then 0xA1–0xA3 on consecutive cycles with out_sof=0.
- IDLE: two words without in_sof → both dropped, sync_err=1, fill_level=0. Then a word with in_sof → PRIME, fill_level=1.
- out_ready=0, write 70 words after sof (start_level=1). fill_level saturates at 65 (64 memory + 1 output register). overflow=1, and exactly 5 words are lost. Read-back order is intact and shows pointer wrap.
- Interleave in_is_pps=1 words (0xFF..) with slice words. No PPS word is ever emitted, and fill_level counts only slice words.
- STREAM, drain to empty with out_ready held high → underflow=1 on the first empty cycle. A new write then resumes output after 2 edges.
- Mid-stream flush while a simultaneous write and read occur → next cycle fill_level=0, out_valid=0, all flags 0, state IDLE. The word written in the flush cycle is not emitted. Also assert rst_n low mid-burst: all outputs go to reset values asynchronously.

Source files
------------

// File: rtl/slice_rate_buffer_pkg.sv
// Shared definitions for the per-slice decoder rate buffer: word width, FSM state codes and the
// position of the start-of-frame tag stored alongside each word.
package slice_rate_buffer_pkg;

    localparam int unsigned DATA_W_DEF = 256;

    typedef logic [1:0] rb_state_t;

    localparam rb_state_t ST_IDLE   = 2'd0;
    localparam rb_state_t ST_PRIME  = 2'd1;
    localparam rb_state_t ST_STREAM = 2'd2;

    // The sof tag sits directly above the data bits of a stored entry.
    function automatic int unsigned sof_tag_bit(input int unsigned data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/rb_ram.sv
// Simple dual-port synchronous RAM with registered read; no reset so it maps onto block RAM.
module rb_ram #(
    parameter int unsigned Depth = 64,
    parameter int unsigned Width = 257,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/slice_rate_buffer.sv
// Per-slice rate buffer: drops PPS words, primes to a programmed fill level, then streams words
// to the substream demux over valid/ready with sticky overflow/underflow/sync error flags.
module slice_rate_buffer
    import slice_rate_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = DATA_W_DEF,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W:0]   start_level,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_is_pps,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic [ADDR_W+1:0] fill_level,
    output logic              overflow,
    output logic              underflow,
    output logic              sync_err
);

    localparam int unsigned SofBit = sof_tag_bit(DATA_W);

    rb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   mem_count_q, mem_count_d;
    logic [ADDR_W+1:0] fill_q, fill_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              sync_err_q, sync_err_d;

    logic              full;
    logic              wr_req;
    logic              wr_en;
    logic              load;
    logic [ADDR_W:0]   level_eff;
    logic [DATA_W:0]   wr_entry;
    logic [DATA_W:0]   rd_entry;

    always_comb begin
        full      = (mem_count_q == (ADDR_W+1)'(DEPTH));
        level_eff = (start_level == '0) ? (ADDR_W+1)'(1) : start_level;
        wr_req    = in_valid & ~in_is_pps & ~flush & ((state_q != ST_IDLE) | in_sof);
        wr_en     = wr_req & ~full;
        load      = ~flush & (state_q == ST_STREAM) & (mem_count_q != '0)
                  & (~out_valid_q | out_ready);
        wr_entry  = {in_sof, in_data};
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q | (wr_req & full);
        underflow_d = underflow_q | ((state_q == ST_STREAM) & out_ready & ~out_valid_q);
        sync_err_d  = sync_err_q
                    | ((state_q == ST_IDLE) & in_valid & ~in_is_pps & ~in_sof);
        out_valid_d = load | (out_valid_q & ~out_ready);
        mem_count_d = mem_count_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(load);

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (load) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (mem_count_q >= level_eff) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: state_d = ST_STREAM;
            default:   state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d     = ST_IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            mem_count_d = '0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            sync_err_d  = 1'b0;
        end

        fill_d = (ADDR_W+2)'(mem_count_d) + (ADDR_W+2)'(out_valid_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // The RAM read register doubles as the output data register; it only advances on a load.
    rb_ram #(
        .Depth (DEPTH),
        .Width (DATA_W + 1)
    ) u_rb_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .re_i    (load),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // RAM contents are unreset, so data is qualified by valid to give clean reset/flush values.
    assign out_data   = out_valid_q ? rd_entry[DATA_W-1:0] : '0;
    assign out_sof    = out_valid_q & rd_entry[SofBit];
    assign out_valid  = out_valid_q;
    assign fill_level = fill_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_slice_rate_buffer.sv
// Self-checking bench for slice_rate_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_slice_rate_buffer;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [ADDR_W:0]   start_level = 7'd4;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_sof = 1'b0;
    logic              in_is_pps = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_sof;
    logic [ADDR_W+1:0] fill_level;
    logic              overflow;
    logic              underflow;
    logic              sync_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    slice_rate_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .start_level (start_level),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .in_is_pps   (in_is_pps),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .fill_level  (fill_level),
        .overflow    (overflow),
        .underflow   (underflow),
        .sync_err    (sync_err)
    );

    // ---------------- reference model: a word queue plus a one-word output slot ----------------
    logic [DATA_W:0] mq[$];
    logic [DATA_W:0] m_out;
    bit              m_ov;
    int              m_state;  // 0 idle, 1 priming, 2 streaming
    bit              m_ovf, m_unf, m_syn;

    function automatic void model_clear();
        mq.delete();
        m_out   = '0;
        m_ov    = 1'b0;
        m_state = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_syn   = 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            model_clear();
        end else begin
            automatic bit slice_word = in_valid && !in_is_pps;
            automatic bit accept     = slice_word && (m_state != 0 || in_sof);
            automatic int cnt        = mq.size();
            automatic int need       = (start_level == 0) ? 1 : int'(start_level);
            automatic bit take       = (m_state == 2) && (cnt > 0) && (!m_ov || out_ready);
            if (m_state == 2 && out_ready && !m_ov) m_unf = 1'b1;
            if (m_state == 0 && slice_word && !in_sof) m_syn = 1'b1;
            if (take) begin
                m_out = mq.pop_front();
                m_ov  = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (accept) begin
                if (cnt == int'(DEPTH)) m_ovf = 1'b1;
                else mq.push_back({in_sof, in_data});
            end
            if (m_state == 0 && accept) m_state = 1;
            else if (m_state == 1 && cnt >= need) m_state = 2;
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            n_tests++;
            if (out_valid !== m_ov || fill_level !== (ADDR_W+2)'(mq.size() + int'(m_ov))
                || overflow !== m_ovf || underflow !== m_unf || sync_err !== m_syn) begin
                n_fail++;
                $display("FAIL model_ctrl t=%0t: got v=%b fill=%0d ov=%b un=%b se=%b, expected v=%b fill=%0d ov=%b un=%b se=%b",
                         $time, out_valid, fill_level, overflow, underflow, sync_err,
                         m_ov, mq.size() + int'(m_ov), m_ovf, m_unf, m_syn);
            end
            if (m_ov) begin
                n_tests++;
                if (out_data !== m_out[DATA_W-1:0] || out_sof !== m_out[DATA_W]) begin
                    n_fail++;
                    $display("FAIL model_data t=%0t: got %h sof=%b, expected %h sof=%b",
                             $time, out_data, out_sof, m_out[DATA_W-1:0], m_out[DATA_W]);
                end
            end
        end
    end

    // Words the consumer accepted, for order/PPS checks.
    logic [63:0] seen[$];
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) seen.push_back(out_data[63:0]);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic p, input logic [DATA_W-1:0] d);
        in_valid  = 1'b1;
        in_sof    = s;
        in_is_pps = p;
        in_data   = d;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_is_pps = 1'b0;
        in_data   = '0;
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        #2;
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_data", out_data[63:0], 0);
        chk("rst_fill", 64'(fill_level), 0);
        chk("rst_flags", {61'd0, overflow, underflow, sync_err}, 0);
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Priming to 4 words, then first-word fall-through two edges after the 4th write.
        start_level = 7'd4;
        out_ready   = 1'b1;
        drive(1'b1, 1'b0, 'hA0); tick();
        chk("t1_fill1", 64'(fill_level), 1);
        drive(1'b0, 1'b0, 'hA1); tick();
        drive(1'b0, 1'b0, 'hA2); tick();
        drive(1'b0, 1'b0, 'hA3); tick();
        chk("t1_nv_at4", 64'(out_valid), 0);
        chk("t1_fill4", 64'(fill_level), 4);
        idle(); tick();
        chk("t1_nv_plus1", 64'(out_valid), 0);
        tick();
        chk("t1_v_plus2", 64'(out_valid), 1);
        chk("t1_d0", out_data[63:0], 'hA0);
        chk("t1_sof0", 64'(out_sof), 1);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t1_dk", out_data[63:0], 64'('hA0 + k));
            chk("t1_sofk", 64'(out_sof), 0);
        end
        tick();
        chk("t1_drained", 64'(out_valid), 0);
        do_flush();
        chk("flush_flags", {61'd0, overflow, underflow, sync_err}, 0);

        // Words in IDLE without sof are dropped and flag sync_err.
        drive(1'b0, 1'b0, 'hB0); tick();
        drive(1'b0, 1'b0, 'hB1); tick();
        chk("t2_sync", 64'(sync_err), 1);
        chk("t2_fill0", 64'(fill_level), 0);
        drive(1'b1, 1'b0, 'hB2); tick();
        chk("t2_fill1", 64'(fill_level), 1);
        do_flush();

        // Overflow: 70 words with no consumer, 65 retained, read back in order across the wrap.
        start_level = 7'd1;
        out_ready   = 1'b0;
        for (int i = 0; i < 70; i++) begin
            drive(i == 0, 1'b0, 256'h100 + 256'(i));
            tick();
        end
        idle(); tick();
        chk("t3_fill_sat", 64'(fill_level), 65);
        chk("t3_ovf", 64'(overflow), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 65; k++) begin
            chk("t3_rb_valid", 64'(out_valid), 1);
            chk("t3_rb_data", out_data[63:0], 64'('h100 + k));
            tick();
        end
        chk("t3_empty", 64'(out_valid), 0);
        chk("t3_fill0", 64'(fill_level), 0);
        do_flush();

        // PPS words interleaved: never stored, never emitted.
        start_level = 7'd2;
        seen.delete();
        drive(1'b1, 1'b0, 'hC0); tick();
        chk("t4_fill_a", 64'(fill_level), 1);
        drive(1'b0, 1'b1, '1); tick();
        chk("t4_fill_pps", 64'(fill_level), 1);
        drive(1'b0, 1'b0, 'hC1); tick();
        chk("t4_fill_b", 64'(fill_level), 2);
        drive(1'b0, 1'b1, '1); tick();
        drive(1'b0, 1'b0, 'hC2); tick();
        drive(1'b0, 1'b1, '1); tick();
        drive(1'b0, 1'b0, 'hC3); tick();
        idle();
        repeat (6) tick();
        chk("t4_count", 64'(seen.size()), 4);
        for (int k = 0; k < 4 && k < seen.size(); k++) chk("t4_word", seen[k], 64'('hC0 + k));
        do_flush();

        // Drain to empty: underflow on the first empty cycle, then a new word 2 edges later.
        start_level = 7'd1;
        out_ready   = 1'b0;
        drive(1'b1, 1'b0, 'hE0); tick();
        drive(1'b0, 1'b0, 'hE1); tick();
        idle(); tick();
        chk("t5_v", 64'(out_valid), 1);
        chk("t5_unf0", 64'(underflow), 0);
        out_ready = 1'b1;
        tick();
        chk("t5_e1", out_data[63:0], 'hE1);
        tick();
        chk("t5_empty", 64'(out_valid), 0);
        chk("t5_unf_not_yet", 64'(underflow), 0);
        tick();
        chk("t5_unf1", 64'(underflow), 1);
        drive(1'b0, 1'b0, 'hD0); tick();
        idle();
        chk("t5_nv_n", 64'(out_valid), 0);
        tick();
        chk("t5_v_n1", 64'(out_valid), 1);
        chk("t5_d0", out_data[63:0], 'hD0);
        chk("t5_sof", 64'(out_sof), 0);

        // Flush during a simultaneous write and read.
        drive(1'b0, 1'b0, 'hD1); tick();
        drive(1'b0, 1'b0, 'hD2); tick();
        chk("t6_pre_v", 64'(out_valid), 1);
        drive(1'b0, 1'b0, 'hD3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("t6_fill", 64'(fill_level), 0);
        chk("t6_v", 64'(out_valid), 0);
        chk("t6_flags", {61'd0, overflow, underflow, sync_err}, 0);
        tick(); tick();
        chk("t6_no_emit", 64'(out_valid), 0);
        drive(1'b0, 1'b0, 'hD9); tick();
        idle();
        chk("t6_idle_sync", 64'(sync_err), 1);
        do_flush();

        // Asynchronous reset mid-burst.
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 'h9); tick();
        drive(1'b1, 1'b0, 'h1); tick();
        drive(1'b0, 1'b0, 'h2); tick();
        drive(1'b0, 1'b0, 'h3); tick();
        chk("t7_pre_v", 64'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_v", 64'(out_valid), 0);
        chk("t7_data", out_data[63:0], 0);
        chk("t7_sof", 64'(out_sof), 0);
        chk("t7_fill", 64'(fill_level), 0);
        chk("t7_flags", {61'd0, overflow, underflow, sync_err}, 0);
        idle(); tick();
        rst_n = 1'b1;
        tick();
        chk("t7_after", 64'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
